// File: rtl/orientation_unit_param.sv
// ---------------------------------------------------------------------------
// orientation_unit_param
//
// Intensity-centroid orientation for ORB descriptors. One window column is
// accepted per i_valid cycle; a systolic chain of N=2R+1 stages builds the
// moments m10 (x-weighted) and m01 (y-weighted) over the last N columns. A
// six-stage post pipeline then normalises them into signed fixed-point
// cos/sin of the patch angle (1.0 = 2^FRAC_W).
//
// Ports
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_col    : one window column, row r in [r*PIX_W +: PIX_W], row 0 on top
//   i_valid  : column present; the only pipeline advance enable
//   i_sol    : start of line, marks the first column of a row
//   o_cos    : signed m10/|m|, FRAC_W fractional bits
//   o_sin    : signed m01/|m|, FRAC_W fractional bits
//   o_valid  : result comes from a fully populated window
//
// Build option
//   ORIENT_CIRCULAR_MASK_EN : when defined, pixels outside the radius-R circle
//                             are zeroed (ORB circular patch); otherwise the
//                             full square window contributes.
// ---------------------------------------------------------------------------
module orientation_unit_param #(
  parameter int RADIUS = 3,
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 10
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [(2*RADIUS+1)*PIX_W-1:0]    i_col,
  input  logic                             i_valid,
  input  logic                             i_sol,
  output logic signed [FRAC_W+1:0]         o_cos,
  output logic signed [FRAC_W+1:0]         o_sin,
  output logic                             o_valid
);

  localparam int N      = 2*RADIUS + 1;
  localparam int SUM_W  = $clog2(((2**PIX_W) - 1) * N * RADIUS * (RADIUS + 1) / 2) + 1;
  localparam int PROD_W = 2*SUM_W;
  localparam int DIV_W  = SUM_W + FRAC_W;
  localparam int Q_W    = FRAC_W + 1;
  localparam int OUT_W  = FRAC_W + 2;
  localparam int CNT_W  = $clog2(N + 1);
  localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(N);
  localparam logic signed [OUT_W-1:0] FIX_ONE  = OUT_W'(2**FRAC_W);

  // Moment chain: stage k holds the partial sums of the columns that will
  // end up at horizontal offset dx = k-R once the window is complete.
  logic signed [SUM_W-1:0] colSum [N];
  logic signed [SUM_W-1:0] colDy  [N];
  logic signed [SUM_W-1:0] m10_d  [N];
  logic signed [SUM_W-1:0] m01_d  [N];
  logic signed [SUM_W-1:0] m10_q  [N];
  logic signed [SUM_W-1:0] m01_q  [N];

  logic [CNT_W-1:0] colCnt_q, colCnt_d;
  logic             full;
  // vld_q[0] travels with the moment result, vld_q[6] is o_valid
  logic [6:0]       vld_q;

  // Post pipeline: magnitudes and signs ride along until they are consumed
  logic [SUM_W-1:0]  absX_d, absY_d;
  logic [SUM_W-1:0]  absX_q [1:4];
  logic [SUM_W-1:0]  absY_q [1:4];
  logic              negX_q [1:5];
  logic              negY_q [1:5];
  logic [PROD_W-1:0] sqX_d, sqY_d, sqX_q, sqY_q;
  logic [PROD_W-1:0] magSq_d, magSq_q;
  logic [SUM_W-1:0]  root_d, root_q;
  logic [DIV_W-1:0]  divisor;
  logic [Q_W-1:0]    quotX_d, quotY_d, quotX_q, quotY_q;
  logic              zero_d, zero_q;
  logic signed [OUT_W-1:0] cos_d, sin_d, cos_q, sin_q;

  // Floor square root, restoring bit-by-bit from the MSB down
  function automatic logic [SUM_W-1:0] isqrt(input logic [PROD_W-1:0] value);
    logic [SUM_W-1:0]  root;
    logic [SUM_W-1:0]  trial;
    logic [PROD_W-1:0] trialWide;
    root      = '0;
    trial     = '0;
    trialWide = '0;
    for (int b = SUM_W-1; b >= 0; b--) begin
      trial     = root | (SUM_W'(1) << b);
      trialWide = PROD_W'(trial);
      if (trialWide * trialWide <= value) root = trial;
    end
    return root;
  endfunction

  // Each stage sees the incoming column with its own row mask; the mask is
  // constant per stage because a stage always applies the same dx.
  always_comb begin : columnWeights
    logic                    used;
    logic signed [SUM_W-1:0] pix;
    used = 1'b0;
    pix  = '0;
    for (int k = 0; k < N; k++) begin
      colSum[k] = '0;
      colDy[k]  = '0;
      for (int r = 0; r < N; r++) begin
`ifdef ORIENT_CIRCULAR_MASK_EN
        used = ((k-RADIUS)*(k-RADIUS) + (r-RADIUS)*(r-RADIUS)) <= RADIUS*RADIUS;
`else
        used = 1'b1;
`endif
        pix = used ? $signed({{(SUM_W-PIX_W){1'b0}}, i_col[r*PIX_W +: PIX_W]}) : '0;
        colSum[k] = colSum[k] + pix;
        colDy[k]  = colDy[k] + SUM_W'(r-RADIUS) * pix;
      end
    end
    m10_d[0] = SUM_W'(-RADIUS) * colSum[0];
    m01_d[0] = colDy[0];
    for (int k = 1; k < N; k++) begin
      m10_d[k] = m10_q[k-1] + SUM_W'(k-RADIUS) * colSum[k];
      m01_d[k] = m01_q[k-1] + colDy[k];
    end
  end

  // Column counter restarts on i_sol and saturates at N
  always_comb begin
    colCnt_d = colCnt_q;
    if (i_sol)                     colCnt_d = CNT_W'(1);
    else if (colCnt_q != CNT_FULL) colCnt_d = colCnt_q + 1'b1;
    full = (colCnt_d == CNT_FULL);
  end

  // Normalisation datapath; a zero-magnitude patch bypasses the divider
  always_comb begin
    absX_d  = m10_q[N-1][SUM_W-1] ? $unsigned(-m10_q[N-1]) : $unsigned(m10_q[N-1]);
    absY_d  = m01_q[N-1][SUM_W-1] ? $unsigned(-m01_q[N-1]) : $unsigned(m01_q[N-1]);
    sqX_d   = PROD_W'(absX_q[1]) * PROD_W'(absX_q[1]);
    sqY_d   = PROD_W'(absY_q[1]) * PROD_W'(absY_q[1]);
    magSq_d = sqX_q + sqY_q;
    root_d  = isqrt(magSq_q);
    zero_d  = (root_q == '0);
    divisor = zero_d ? DIV_W'(1) : DIV_W'(root_q);
    quotX_d = Q_W'({absX_q[4], {FRAC_W{1'b0}}} / divisor);
    quotY_d = Q_W'({absY_q[4], {FRAC_W{1'b0}}} / divisor);
    if (zero_q) begin
      cos_d = FIX_ONE;
      sin_d = '0;
    end else begin
      cos_d = negX_q[5] ? -$signed({1'b0, quotX_q}) : $signed({1'b0, quotX_q});
      sin_d = negY_q[5] ? -$signed({1'b0, quotY_q}) : $signed({1'b0, quotY_q});
    end
  end

  // All state advances only on accepted columns
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N; k++) begin
        m10_q[k] <= '0;
        m01_q[k] <= '0;
      end
      for (int s = 1; s <= 4; s++) begin
        absX_q[s] <= '0;
        absY_q[s] <= '0;
      end
      for (int s = 1; s <= 5; s++) begin
        negX_q[s] <= 1'b0;
        negY_q[s] <= 1'b0;
      end
      colCnt_q <= '0;
      vld_q    <= '0;
      sqX_q    <= '0;
      sqY_q    <= '0;
      magSq_q  <= '0;
      root_q   <= '0;
      quotX_q  <= '0;
      quotY_q  <= '0;
      zero_q   <= 1'b0;
      cos_q    <= '0;
      sin_q    <= '0;
    end else if (i_valid) begin
      for (int k = 0; k < N; k++) begin
        m10_q[k] <= m10_d[k];
        m01_q[k] <= m01_d[k];
      end
      absX_q[1] <= absX_d;
      absY_q[1] <= absY_d;
      negX_q[1] <= m10_q[N-1][SUM_W-1];
      negY_q[1] <= m01_q[N-1][SUM_W-1];
      for (int s = 2; s <= 4; s++) begin
        absX_q[s] <= absX_q[s-1];
        absY_q[s] <= absY_q[s-1];
      end
      for (int s = 2; s <= 5; s++) begin
        negX_q[s] <= negX_q[s-1];
        negY_q[s] <= negY_q[s-1];
      end
      colCnt_q <= colCnt_d;
      vld_q    <= {vld_q[5:0], full};
      sqX_q    <= sqX_d;
      sqY_q    <= sqY_d;
      magSq_q  <= magSq_d;
      root_q   <= root_d;
      quotX_q  <= quotX_d;
      quotY_q  <= quotY_d;
      zero_q   <= zero_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
    end
  end

  assign o_cos   = cos_q;
  assign o_sin   = sin_q;
  assign o_valid = vld_q[6];

endmodule
